// File: rtl/tmds_pkg.sv
// TMDS channel decoding shared definitions.
// Holds the four DVI control-token code words, the alignment FSM state
// encoding and the per-word decode function (also intended for TERC4 reuse).
package tmds_pkg;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'h354;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'h0AB;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'h154;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'h2AB;

    typedef enum logic [1:0] {
        ST_SEARCH    = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_LOCKED    = 2'd2
    } tmds_state_e;

    typedef struct packed {
        logic       is_ctrl;
        logic [1:0] ctrl;
        logic [7:0] data;
    } tmds_dec_t;

    // Classify one 10-bit TMDS word and decode it. Control words yield their
    // {c1,c0} value with data forced to zero; everything else is treated as
    // video data and undone through the DC-balance and XOR/XNOR stages.
    function automatic tmds_dec_t tmds_decode(input logic [9:0] q);
        tmds_dec_t  r;
        logic [7:0] d;
        r = '0;
        d = q[9] ? ~q[7:0] : q[7:0];
        case (q)
            CTRL_TOKEN_00: begin r.is_ctrl = 1'b1; r.ctrl = 2'b00; end
            CTRL_TOKEN_01: begin r.is_ctrl = 1'b1; r.ctrl = 2'b01; end
            CTRL_TOKEN_10: begin r.is_ctrl = 1'b1; r.ctrl = 2'b10; end
            CTRL_TOKEN_11: begin r.is_ctrl = 1'b1; r.ctrl = 2'b11; end
            default: begin
                r.is_ctrl = 1'b0;
                r.ctrl    = 2'b00;
                r.data[0] = d[0];
                for (int i = 1; i < 8; i++) begin
                    r.data[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
                end
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// Two-stage TMDS word decoder.
// Stage 1 registers the raw word; stage 2 registers the decoded result.
// Ports:
//   clk, resetn    - pixel clock, async active-low reset
//   tmds_word      - deserialized 10-bit channel word
//   stage1_ctrl    - stage-1 word is a control token (feeds lock logic)
//   de, data, ctrl - registered decode results (ctrl holds during data)
module tmds_word_decode
    import tmds_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [9:0] tmds_word,
    output logic       stage1_ctrl,
    output logic       de,
    output logic [7:0] data,
    output logic [1:0] ctrl
);

    logic [9:0] word_r;
    tmds_dec_t  dec_s;
    logic       de_r;
    logic [7:0] data_r;
    logic [1:0] ctrl_r;

    // Stage 1: capture the incoming word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word_r <= 10'h000;
        end else begin
            word_r <= tmds_word;
        end
    end

    assign dec_s       = tmds_decode(word_r);
    assign stage1_ctrl = dec_s.is_ctrl;

    // Stage 2: register decoded outputs; ctrl keeps the last token value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            de_r   <= 1'b0;
            data_r <= 8'h00;
            ctrl_r <= 2'b00;
        end else begin
            de_r   <= ~dec_s.is_ctrl;
            data_r <= dec_s.data;
            if (dec_s.is_ctrl) begin
                ctrl_r <= dec_s.ctrl;
            end else begin
                ctrl_r <= ctrl_r;
            end
        end
    end

    assign de   = de_r;
    assign data = data_r;
    assign ctrl = ctrl_r;

endmodule

// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder with word-boundary alignment.
// Decodes one 10-bit word per cycle (latency 2) and searches for a run of
// LOCK_RUN control tokens, requesting bitslips until the boundary is found.
// Ports:
//   clk, resetn    - pixel clock, async active-low reset
//   tmds_word      - deserialized word, bit 0 first on the wire
//   bitslip        - one-cycle request to rotate the word boundary
//   aligned        - high while locked
//   de, data, ctrl - decoded outputs, produced in every state
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int SLIP_WAIT  = 16,
    parameter int LOCK_RUN   = 8,
    parameter int SEARCH_WIN = 4096,
    parameter int LOSS_WIN   = 65536
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [9:0] tmds_word,
    output logic       bitslip,
    output logic       aligned,
    output logic       de,
    output logic [7:0] data,
    output logic [1:0] ctrl
);

    // Run counter must be able to hold LOCK_RUN itself (it saturates there).
    localparam int RUN_W  = $clog2(LOCK_RUN + 1);
    localparam int WIN_W  = (SEARCH_WIN > 1) ? $clog2(SEARCH_WIN) : 1;
    localparam int LOSS_W = (LOSS_WIN > 1)   ? $clog2(LOSS_WIN)   : 1;
    localparam int SLIP_W = (SLIP_WAIT > 1)  ? $clog2(SLIP_WAIT)  : 1;

    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(LOCK_RUN);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WIN - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_WIN - 1);
    localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(SLIP_WAIT - 1);

    logic              stage1_ctrl_s;
    tmds_state_e       state_r,    state_s;
    logic [RUN_W-1:0]  run_r,      run_s;
    logic [WIN_W-1:0]  win_r,      win_s;
    logic [LOSS_W-1:0] loss_r,     loss_s;
    logic [SLIP_W-1:0] slip_cnt_r, slip_cnt_s;
    logic              bitslip_r,  bitslip_s;
    logic              aligned_r;

    tmds_word_decode u_decode (
        .clk         (clk),
        .resetn      (resetn),
        .tmds_word   (tmds_word),
        .stage1_ctrl (stage1_ctrl_s),
        .de          (de),
        .data        (data),
        .ctrl        (ctrl)
    );

    // Next-state, counter and bitslip logic for the alignment FSM.
    always_comb begin
        state_s    = state_r;
        win_s      = win_r;
        loss_s     = loss_r;
        slip_cnt_s = slip_cnt_r;
        bitslip_s  = 1'b0;
        if (!stage1_ctrl_s) begin
            run_s = '0;
        end else if (run_r != RUN_MAX) begin
            run_s = run_r + RUN_W'(1);
        end else begin
            run_s = run_r;
        end

        case (state_r)
            ST_SEARCH: begin
                // A completed run wins over a simultaneous window expiry.
                if (run_r == RUN_MAX) begin
                    state_s = ST_LOCKED;
                    loss_s  = '0;
                end else if (win_r == WIN_LAST) begin
                    state_s    = ST_SLIP_WAIT;
                    bitslip_s  = 1'b1;
                    slip_cnt_s = '0;
                    run_s      = '0;
                end else begin
                    win_s = win_r + WIN_W'(1);
                end
            end
            ST_SLIP_WAIT: begin
                // Input is meaningless while the deserializer re-aligns.
                run_s = '0;
                win_s = '0;
                if (slip_cnt_r == SLIP_LAST) begin
                    state_s    = ST_SEARCH;
                    slip_cnt_s = '0;
                end else begin
                    slip_cnt_s = slip_cnt_r + SLIP_W'(1);
                end
            end
            ST_LOCKED: begin
                if (run_r == RUN_MAX) begin
                    loss_s = '0;
                end else if (loss_r == LOSS_LAST) begin
                    state_s = ST_SEARCH;
                    win_s   = '0;
                    loss_s  = '0;
                end else begin
                    loss_s = loss_r + LOSS_W'(1);
                end
            end
            default: begin
                state_s    = ST_SEARCH;
                run_s      = '0;
                win_s      = '0;
                loss_s     = '0;
                slip_cnt_s = '0;
            end
        endcase
    end

    // FSM state, counters and registered control outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_SEARCH;
            run_r      <= '0;
            win_r      <= '0;
            loss_r     <= '0;
            slip_cnt_r <= '0;
            bitslip_r  <= 1'b0;
            aligned_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            run_r      <= run_s;
            win_r      <= win_s;
            loss_r     <= loss_s;
            slip_cnt_r <= slip_cnt_s;
            bitslip_r  <= bitslip_s;
            aligned_r  <= (state_s == ST_LOCKED);
        end
    end

    assign bitslip = bitslip_r;
    assign aligned = aligned_r;

endmodule

// File: doc/tmds_channel_decoder.md
TMDS_CHANNEL_DECODER -- requirements
Module: tmds_channel_decoder

Interface
REQ-001 SHALL have parameter SLIP_WAIT, default 16: cycles held in SLIP_WAIT after each bitslip pulse.
REQ-002 SHALL have parameter LOCK_RUN, default 8: consecutive control tokens required to lock.
REQ-003 SHALL have parameter SEARCH_WIN, default 4096: cycles in SEARCH without a lock run before slipping.
REQ-004 SHALL have parameter LOSS_WIN, default 65536: cycles in LOCKED without a LOCK_RUN control run before dropping lock.
REQ-005 SHALL have port clk  input  1  pixel clock; one 10-bit TMDS word per cycle; single clock domain.
REQ-006 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port tmds_word  input  10  deserialized channel word, bit 0 first on the wire.
REQ-008 SHALL have port bitslip  output  1  one-cycle pulse asking the deserializer to rotate word boundary by one bit.
REQ-009 SHALL have port aligned  output  1  high while in LOCKED.
REQ-010 SHALL have port de  output  1  data-enable: decoded word is video data.
REQ-011 SHALL have port data  output  8  decoded pixel byte, valid when de=1.
REQ-012 SHALL have port ctrl  output  2  {c1,c0} from control token, valid when de=0.

Function
REQ-013 SHALL register tmds_word into stage 1; SHALL drive de/data/ctrl from stage 2 registers: fixed latency 2 cycles from tmds_word to outputs.
REQ-014 SHALL classify stage-1 word as control if equal to 10'h354 (ctrl=00), 10'h0AB (01), 10'h154 (10), 10'h2AB (11); otherwise data.
REQ-015 For control words SHALL output de=0, ctrl=token value, data=8'h00.
REQ-016 For data words SHALL output de=1, ctrl held at previous value; d=q[9]?~q[7:0]:q[7:0]; data[0]=d[0]; data[i]=q[8]?d[i]^d[i-1]:~(d[i]^d[i-1]) for i=1..7.
REQ-017 SHALL keep a run counter of consecutive control words, saturating at LOCK_RUN, cleared by any data word.
REQ-018 SHALL implement FSM states SEARCH, SLIP_WAIT, LOCKED; reset state SEARCH.
REQ-019 SEARCH: run counter reaching LOCK_RUN -> LOCKED; else window counter reaching SEARCH_WIN-1 -> assert bitslip one cycle, go SLIP_WAIT.
REQ-020 SLIP_WAIT: count SLIP_WAIT cycles, clear run and window counters, ignore input, then -> SEARCH; bitslip SHALL never be asserted in SLIP_WAIT or LOCKED.
REQ-021 LOCKED: loss counter cleared each time run counter reaches LOCK_RUN; loss counter reaching LOSS_WIN-1 -> SEARCH with aligned deasserting next cycle, no bitslip that cycle.
REQ-022 Lock-run completion and window expiry in the same SEARCH cycle SHALL resolve to LOCKED (no slip).
REQ-023 Decoded outputs SHALL be produced in all states; consumers qualify with aligned.
REQ-024 Counters SHALL be sized by $clog2 of their parameter and SHALL NOT wrap.

Reset
REQ-025 Asserting resetn low at any time SHALL immediately force: state SEARCH, all counters 0, bitslip 0, aligned 0, de 0, data 8'h00, ctrl 2'b00, pipeline registers 0.
REQ-026 After resetn release, first valid output SHALL appear 2 cycles after the first sampled word.

Structure
REQ-027 Package tmds_pkg SHALL hold the four control-token constants, the FSM state enum, and the decode function shared with future TERC4 logic.
REQ-028 One sub-module tmds_word_decode SHALL implement stages 1-2 (classification, data decode, registers); FSM and counters live in the top.

Verification
REQ-029 Reset: hold resetn=0 with tmds_word=10'h354 -> all outputs 0; release -> de=0, ctrl=00 two cycles later.
REQ-030 Decode: encode bytes 8'h00, 8'hFF, 8'hA5, 8'h10 with reference DVI encoder -> data matches, de=1, exactly 2-cycle latency.
REQ-031 Lock: feed 8 consecutive 10'h2AB then data -> aligned rises on the cycle after the 8th token is counted; ctrl=11.
REQ-032 Slip: stream rotated by 3 bits, SEARCH_WIN=64 -> exactly 3 bitslip pulses spaced SEARCH_WIN+SLIP_WAIT apart (model rotates), then aligned=1.
REQ-033 Loss: LOSS_WIN=256, after lock feed only data words 256 cycles -> aligned falls, no bitslip that cycle.
REQ-034 Mid-operation reset: assert resetn in LOCKED and during SLIP_WAIT -> aligned=0, bitslip=0 immediately, FSM restarts in SEARCH.
